conv3x3_relu: RTL

- Single-channel 3x3 "same"-padded convolution with bias, saturation and ReLU.
- Sits directly upstream of the 2x2 max-pool stage and feeds it a full IMAGE_HEIGHT x IMAGE_WIDTH feature map over feature_if.
- Buffers one input frame, then computes each output pixel with one sequential multiply-accumulate (9 cycles per pixel).
- Streams each result out, in raster order, as soon as it is ready.

---
 rtl/conv3x3_relu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_relu.sv
// conv3x3_relu: buffers one frame, then computes a 3x3 zero-padded convolution with bias and saturation,
// one sequential MAC per output pixel. Macro CONV3X3_RELU_EN adds a ReLU clamp; undefined gives a linear stage.
module conv3x3_relu #(
  parameter int unsigned IMAGE_HEIGHT  = 28,
  parameter int unsigned IMAGE_WIDTH   = 28,
  parameter int unsigned FRAC_BITS     = 8,
  parameter int unsigned FEATURE_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         features_in_valid,
  output logic                         features_in_ready,
  input  logic [FEATURE_WIDTH-1:0]     features_in_features,
  output logic                         features_out_valid,
  input  logic                         features_out_ready,
  output logic [FEATURE_WIDTH-1:0]     features_out_features,
  input  logic [9*FEATURE_WIDTH-1:0]   weights,
  input  logic [FEATURE_WIDTH-1:0]     bias
);

  localparam int unsigned W     = FEATURE_WIDTH;
  localparam int unsigned ACC_W = 2 * W + 4;
  localparam int unsigned TAPS  = 9;
  localparam int unsigned ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_MAC  = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0]        in_row_q, out_row_q, tap_row_c;
  logic [COL_W-1:0]        in_col_q, out_col_q, tap_col_c;
  logic [3:0]              tap_q;
  logic [1:0]              kr_q, kc_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [W-1:0]            weights_q [TAPS];
  logic [W-1:0]            bias_q;
  logic [W-1:0]            image [IMAGE_HEIGHT][IMAGE_WIDTH];
  logic                    ready_q, valid_q;
  logic [W-1:0]            result_q;

  logic in_beat_c, in_last_c, out_beat_c, out_last_c, mac_done_c;
  logic ready_d, valid_d, load_params_c, mac_step_c, result_load_c;

  logic                    row_ok_c, col_ok_c;
  logic [W-1:0]            pixel_c, weight_c, sat_c, result_c;
  logic signed [2*W-1:0]   pix_ext_c, wt_ext_c, prod_c;
  logic signed [ACC_W-1:0] bias_ext_c, sum_c, shifted_c;

  assign features_in_ready     = ready_q;
  assign features_out_valid    = valid_q;
  assign features_out_features = result_q;

  assign in_beat_c  = features_in_valid && ready_q;
  assign out_beat_c = valid_q && features_out_ready;
  assign in_last_c  = (in_row_q == ROW_W'(IMAGE_HEIGHT - 1)) && (in_col_q == COL_W'(IMAGE_WIDTH - 1));
  assign out_last_c = (out_row_q == ROW_W'(IMAGE_HEIGHT - 1)) && (out_col_q == COL_W'(IMAGE_WIDTH - 1));
  assign mac_done_c = (tap_q == 4'd9);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RECV;
      ST_RECV: if (in_beat_c && in_last_c) state_d = ST_MAC;
      ST_MAC:  if (mac_done_c) state_d = ST_SEND;
      ST_SEND: if (out_beat_c) state_d = out_last_c ? ST_IDLE : ST_MAC;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control decode; handshake flags are registered from the next state so they track the state register
  always_comb begin
    load_params_c = 1'b0;
    mac_step_c    = 1'b0;
    result_load_c = 1'b0;
    case (state_q)
      ST_IDLE: load_params_c = 1'b1;
      ST_MAC: begin
        mac_step_c    = !mac_done_c;
        result_load_c = mac_done_c;
      end
      default: ;
    endcase
    ready_d = (state_d == ST_RECV);
    valid_d = (state_d == ST_SEND);
  end

  // Tap fetch with zero padding, multiply, and final bias/shift/saturate/ReLU
  always_comb begin
    tap_row_c = out_row_q + ROW_W'(kr_q) - ROW_W'(1);
    tap_col_c = out_col_q + COL_W'(kc_q) - COL_W'(1);
    row_ok_c  = !((kr_q == 2'd0) && (out_row_q == '0)) &&
                !((kr_q == 2'd2) && (out_row_q == ROW_W'(IMAGE_HEIGHT - 1)));
    col_ok_c  = !((kc_q == 2'd0) && (out_col_q == '0)) &&
                !((kc_q == 2'd2) && (out_col_q == COL_W'(IMAGE_WIDTH - 1)));

    pixel_c  = '0;
    weight_c = '0;
    if (mac_step_c) begin
      weight_c = weights_q[tap_q];
      if (row_ok_c && col_ok_c) pixel_c = image[tap_row_c][tap_col_c];
    end
    pix_ext_c = {{W{pixel_c[W-1]}}, pixel_c};
    wt_ext_c  = {{W{weight_c[W-1]}}, weight_c};
    prod_c    = pix_ext_c * wt_ext_c;

    bias_ext_c = {{(ACC_W - W){bias_q[W-1]}}, bias_q};
    sum_c      = acc_q + (bias_ext_c <<< FRAC_BITS);
    shifted_c  = sum_c >>> FRAC_BITS;

    if (shifted_c[ACC_W-1:W-1] == {(ACC_W - W + 1){shifted_c[ACC_W-1]}}) begin
      sat_c = shifted_c[W-1:0];
    end else if (shifted_c[ACC_W-1]) begin
      sat_c = {1'b1, {(W - 1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(W - 1){1'b1}}};
    end

`ifdef CONV3X3_RELU_EN
    result_c = sat_c[W-1] ? '0 : sat_c;
`else
    result_c = sat_c;
`endif
  end

  // Counters, accumulator, parameter latches and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      in_row_q  <= '0;
      in_col_q  <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      tap_q     <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      acc_q     <= '0;
      bias_q    <= '0;
      for (int k = 0; k < int'(TAPS); k++) weights_q[k] <= '0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;

      if (load_params_c) begin
        in_row_q  <= '0;
        in_col_q  <= '0;
        out_row_q <= '0;
        out_col_q <= '0;
        bias_q    <= bias;
        for (int k = 0; k < int'(TAPS); k++) weights_q[k] <= weights[k*W +: W];
      end

      if (in_beat_c) begin
        if (in_col_q == COL_W'(IMAGE_WIDTH - 1)) begin
          in_col_q <= '0;
          in_row_q <= (in_row_q == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : in_row_q + ROW_W'(1);
        end else begin
          in_col_q <= in_col_q + COL_W'(1);
        end
      end

      // The accumulator and tap walk sit at zero outside ST_MAC so every pixel starts clean
      if (mac_step_c) begin
        acc_q <= acc_q + {{(ACC_W - 2 * W){prod_c[2*W-1]}}, prod_c};
        tap_q <= tap_q + 4'd1;
        if (kc_q == 2'd2) begin
          kc_q <= 2'd0;
          kr_q <= kr_q + 2'd1;
        end else begin
          kc_q <= kc_q + 2'd1;
        end
      end else if (state_q != ST_MAC) begin
        acc_q <= '0;
        tap_q <= '0;
        kr_q  <= '0;
        kc_q  <= '0;
      end

      if (result_load_c) result_q <= result_c;

      if (out_beat_c) begin
        if (out_col_q == COL_W'(IMAGE_WIDTH - 1)) begin
          out_col_q <= '0;
          out_row_q <= (out_row_q == ROW_W'(IMAGE_HEIGHT - 1)) ? '0 : out_row_q + ROW_W'(1);
        end else begin
          out_col_q <= out_col_q + COL_W'(1);
        end
      end
    end
  end

  // Frame buffer; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    if (in_beat_c) image[in_row_q][in_col_q] <= features_in_features;
  end

endmodule
